fp_align_unit: RTL and testbench

FP_ALIGN_UNIT -- requirements
Module: fp_align_unit

---
 rtl/fp_align_if.sv | 34 +++
 rtl/fp_align_unit.sv | 94 +++++++++
 tb/tb_fp_align_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fp_align_if.sv
// Operand/result handshake bundle between the FP adder front end and the alignment unit.
interface fp_align_if #(
  parameter int FRAC_W = 4,
  parameter int EXP_W  = 3
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int MW = FRAC_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      a_in;
  logic [W-1:0]      b_in;
  logic              out_valid;
  logic              out_ready;
  logic              big_sign;
  logic              small_sign;
  logic [EXP_W-1:0]  exp_out;
  logic [MW-1:0]     big_mant;
  logic [MW-1:0]     small_mant;
  logic [2:0]        grs;
  logic              swapped;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, big_sign, small_sign, exp_out,
           big_mant, small_mant, grs, swapped
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, big_sign, small_sign, exp_out,
           big_mant, small_mant, grs, swapped
  );
endinterface

// File: rtl/fp_align_unit.sv
// Orders two FP operands by magnitude and right-shifts the smaller mantissa one bit
// per cycle to the larger exponent, collecting guard/round/sticky.
module fp_align_unit #(
  parameter int FRAC_W = 4,
  parameter int EXP_W  = 3
) (
  input  logic      clk,
  input  logic      rst,
  fp_align_if.slave bus
);
  localparam int W    = 1 + EXP_W + FRAC_W;
  localparam int MW   = FRAC_W + 1;
  localparam int DMAX = FRAC_W + 3;
  localparam int CW   = $clog2(DMAX + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              big_sign_q, small_sign_q, swapped_q;
  logic [EXP_W-1:0]  exp_q;
  logic [MW-1:0]     big_mant_q, small_mant_q;
  logic              g_q, r_q, s_q;

  logic [EXP_W-1:0]  a_exp, b_exp, a_eexp, b_eexp, diff;
  logic [MW-1:0]     a_mant, b_mant;
  logic              b_big;
  logic [CW-1:0]     d_clamp;

  // Denormals (exp==0) have no hidden bit but share exponent 1 with the smallest normals.
  always_comb begin
    a_exp  = bus.a_in[W-2 -: EXP_W];
    b_exp  = bus.b_in[W-2 -: EXP_W];
    a_eexp = (a_exp != '0) ? a_exp : EXP_W'(1);
    b_eexp = (b_exp != '0) ? b_exp : EXP_W'(1);
    a_mant = {(a_exp != '0), bus.a_in[FRAC_W-1:0]};
    b_mant = {(b_exp != '0), bus.b_in[FRAC_W-1:0]};
    b_big  = (b_eexp > a_eexp) || ((b_eexp == a_eexp) && (b_mant > a_mant));
    diff   = b_big ? (b_eexp - a_eexp) : (a_eexp - b_eexp);
    // Beyond DMAX shifts the whole mantissa already sits in sticky.
    if (int'(diff) > DMAX) d_clamp = CW'(DMAX);
    else                   d_clamp = CW'(diff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      big_sign_q   <= 1'b0;
      small_sign_q <= 1'b0;
      swapped_q    <= 1'b0;
      exp_q        <= '0;
      big_mant_q   <= '0;
      small_mant_q <= '0;
      g_q          <= 1'b0;
      r_q          <= 1'b0;
      s_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          swapped_q    <= b_big;
          big_sign_q   <= b_big ? bus.b_in[W-1] : bus.a_in[W-1];
          small_sign_q <= b_big ? bus.a_in[W-1] : bus.b_in[W-1];
          exp_q        <= b_big ? b_eexp : a_eexp;
          big_mant_q   <= b_big ? b_mant : a_mant;
          small_mant_q <= b_big ? a_mant : b_mant;
          g_q          <= 1'b0;
          r_q          <= 1'b0;
          s_q          <= 1'b0;
          cnt_q        <= d_clamp;
          state_q      <= (d_clamp != '0) ? SHIFT : DONE;
        end
        SHIFT: begin
          {small_mant_q, g_q, r_q} <= {1'b0, small_mant_q, g_q};
          s_q   <= s_q | r_q;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= DONE;
        end
        DONE: if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.big_sign   = big_sign_q;
  assign bus.small_sign = small_sign_q;
  assign bus.exp_out    = exp_q;
  assign bus.big_mant   = big_mant_q;
  assign bus.small_mant = small_mant_q;
  assign bus.grs        = {g_q, r_q, s_q};
  assign bus.swapped    = swapped_q;
endmodule

// File: tb/tb_fp_align_unit.sv
// Directed vector bench for fp_align_unit: ordering, shift/GRS, latency, backpressure, reset.
module tb_fp_align_unit;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  fp_align_if #(.FRAC_W(4), .EXP_W(3)) bus ();
  fp_align_unit #(.FRAC_W(4), .EXP_W(3)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b;
    int         lat;
    logic       swp, bs, ss;
    logic [2:0] e;
    logic [4:0] bm, sm;
    logic [2:0] grs;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " in_ready"},   32'(bus.in_ready), 32'd1);
    chk({tag, " out_valid"},  32'(bus.out_valid), 32'd0);
    chk({tag, " data"}, {13'd0, bus.big_sign, bus.small_sign, bus.swapped, bus.exp_out,
                         bus.big_mant, bus.small_mant, bus.grs}, 32'd0);
  endtask

  // Presents one operand pair and waits (bounded) for out_valid; returns edge count.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, output int edges);
    @(negedge clk);
    bus.a_in = a; bus.b_in = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    edges = 1;
    while (!bus.out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic check_vec(input int i, input vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    chk({t, " swapped"},    32'(bus.swapped),    32'(v.swp));
    chk({t, " big_sign"},   32'(bus.big_sign),   32'(v.bs));
    chk({t, " small_sign"}, 32'(bus.small_sign), 32'(v.ss));
    chk({t, " exp_out"},    32'(bus.exp_out),    32'(v.e));
    chk({t, " big_mant"},   32'(bus.big_mant),   32'(v.bm));
    chk({t, " small_mant"}, 32'(bus.small_mant), 32'(v.sm));
    chk({t, " grs"},        32'(bus.grs),        32'(v.grs));
  endtask

  task automatic release_result(input string t);
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
    chk({t, " idle in_ready"},  32'(bus.in_ready),  32'd1);
    chk({t, " idle out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int   edges;
    logic [31:0] snap;

    //            a      b      lat swp bs   ss   e     bm     sm     grs
    vecs[0] = '{8'h35, 8'h12, 3, 0, 0, 0, 3'd3, 5'h15, 5'h04, 3'b100};
    vecs[1] = '{8'h42, 8'hC7, 1, 1, 1, 0, 3'd4, 5'h17, 5'h12, 3'b000};
    vecs[2] = '{8'h01, 8'h7F, 7, 1, 0, 0, 3'd7, 5'h1F, 5'h00, 3'b001};
    vecs[3] = '{8'h00, 8'h00, 1, 0, 0, 0, 3'd1, 5'h00, 5'h00, 3'b000};
    vecs[4] = '{8'h35, 8'h35, 1, 0, 0, 0, 3'd3, 5'h15, 5'h15, 3'b000};
    vecs[5] = '{8'h9B, 8'h2C, 2, 1, 0, 1, 3'd2, 5'h1C, 5'h0D, 3'b100};
    vecs[6] = '{8'h70, 8'h0F, 7, 0, 0, 0, 3'd7, 5'h10, 5'h00, 3'b001};
    vecs[7] = '{8'hD8, 8'h53, 1, 0, 1, 0, 3'd5, 5'h18, 5'h13, 3'b000};

    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a_in = '0; bus.b_in = '0;
    repeat (2) @(posedge clk);
    #1 chk_zero_outputs("reset");
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b, edges);
      chk($sformatf("v%0d latency", i), 32'(edges), 32'(vecs[i].lat));
      check_vec(i, vecs[i]);
      release_result($sformatf("v%0d", i));
    end

    // Backpressure: result held for 5 cycles, stray operands ignored while DONE.
    launch(8'h35, 8'h12, edges);
    chk("hold latency", 32'(edges), 32'd3);
    snap = {16'd0, bus.swapped, bus.exp_out, bus.big_mant, bus.small_mant, bus.grs};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); bus.in_valid = 1'b1; bus.a_in = 8'h7F; bus.b_in = 8'h01;
      @(posedge clk); #1;
      chk($sformatf("hold%0d out_valid", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("hold%0d in_ready", c),  32'(bus.in_ready),  32'd0);
      chk($sformatf("hold%0d data", c),
          {16'd0, bus.swapped, bus.exp_out, bus.big_mant, bus.small_mant, bus.grs}, snap);
    end
    @(negedge clk); bus.in_valid = 1'b0;
    release_result("hold");
    chk("idle data held", {16'd0, bus.swapped, bus.exp_out, bus.big_mant, bus.small_mant, bus.grs}, snap);

    // Reset on the third SHIFT cycle of the d=6 case.
    @(negedge clk);
    bus.a_in = 8'h01; bus.b_in = 8'h7F; bus.in_valid = 1'b1;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    chk("rst in_ready shifting", 32'(bus.in_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    chk_zero_outputs("midshift rst");
    @(negedge clk); rst = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    edges = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) edges++;
    end
    chk("no out_valid after rst", 32'(edges), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
